sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

Message-schedule and round-constant stage that sits directly upstream of `sha256_hash_core`. It accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready interface. It then streams W_t and K_t for rounds 0..63, one round per cycle, together with the round-enable strobe that drives the hash core's `en_i`. The block uses a 16-word sliding window, so only 16 schedule words are stored at any time.

## Interface
- No parameters. Word width is fixed at 32 and the round count is fixed at 64.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `word_valid_i` in 1: a message word is presented on `word_i`.
- `word_i` in 32: message word. Word 0 (W_0) arrives first.
- `word_ready_o` out 1: the block can accept a word.
- `en_o` out 1: round strobe. Connects to the hash core's `en_i`.
- `Wt_o` out 32: schedule word for the current round. Connects to `Wt_i`.
- `Kt_o` out 32: round constant for the current round. Connects to `Kt_i`.
- `done_o` out 1: one-cycle pulse after round 63 has been issued.
- `stall_i` in 1: present only when `SHA256_SCHED_STALL_EN` is defined. Freezes round issue.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. The FSM also uses a 4-bit word counter `wc`, a 6-bit round counter `t`, and window registers `w[0..15]`, where `w[0]` is the oldest word.
- **IDLE**
  - `word_ready_o`=1.
  - On an accepted word (valid&ready): write the word to `w[15]` after shifting the window down by one, set `wc`=1, and go to LOAD.
- **LOAD**
  - `word_ready_o`=1.
  - Each accepted word shifts into `w[15]` and increments `wc`.
  - When the word accepted with `wc`=15 (the 16th word) is taken: clear `t` to 0 and go to RUN.
  - No timeout applies: gaps between words are allowed indefinitely.
- **RUN**
  - `word_ready_o`=0, and `word_valid_i` is ignored.
  - Each cycle:
    - `en_o`=1, `Wt_o`=`w[0]`, `Kt_o`=K[`t`] from an internal 64-entry FIPS 180-4 constant ROM.
    - On the clock edge the window shifts down one place and `w[15]` is loaded with σ1(`w[14]`) + `w[9]` + σ0(`w[1]`) + `w[0]`, computed mod 2^32.
    - σ0 = ROTR7 ^ ROTR18 ^ SHR3.
    - σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - The same uniform update is used for every round; rounds 0..15 do not need special-casing, because the window holds W_t..W_{t+15}.
  - `t` increments each round. After the round with `t`=63, go to DONE.
- **DONE**
  - `done_o`=1 for exactly one cycle, `en_o`=0, then go to IDLE.
- **Outputs outside RUN**
  - `Wt_o`=0 and `Kt_o`=0 whenever `en_o`=0.
  - `done_o`=0 outside DONE.
- **Reset**
  - Asserting `rst_n` at any time, including mid-LOAD or mid-RUN, immediately forces IDLE and clears `wc`, `t`, and `w[*]`.
  - Any partial block is discarded, and `en_o` drops with no further rounds issued.
- **Hash-core control:** the hash core's `ld_i` is driven by the system controller, not by this block.

## Timing
- **Reset values:** `word_ready_o`=1 (IDLE), `en_o`=0, `Wt_o`=0, `Kt_o`=0, `done_o`=0.
- **Load:** one word per cycle at full rate, so the minimum LOAD is 16 cycles.
- **Load to first round:** `en_o` rises on the cycle after the 16th word is accepted.
- **Round issue:** 64 consecutive `en_o` cycles with no stall.
- **Done:** `done_o` is asserted on the cycle after the last `en_o`.
- **Next block:** `word_ready_o` rises on the cycle after `done_o`.
- **Block latency:** 16 + 64 + 1 cycles from the first accepted word to `done_o`, at full rate.
- **Output timing:** `en_o`, `Wt_o` and `Kt_o` are decoded only from state, `t` and `w[0]`, with no input-to-output combinational path. The hash core samples them on the same clock edge that advances `t`.

## Configuration
- **`SHA256_SCHED_STALL_EN` defined:**
  - Adds `stall_i`.
  - When `stall_i`=1 in RUN: `en_o`=0, `Wt_o`/`Kt_o`=0, and `t` and `w[*]` hold.
  - Issue resumes at the same `t` on the cycle after `stall_i` falls.
  - `stall_i` has no effect in IDLE, LOAD or DONE.
- **Undefined:** no port; RUN always issues back-to-back rounds.

## Test plan
- **Reset:** hold `rst_n`=0, then release → `word_ready_o`=1, `en_o`=0, `Wt_o`=0, `Kt_o`=0, `done_o`=0.
- **"abc" block schedule:** load 0x61626380, fourteen words of 0x00000000, then 0x00000018 at full rate. Required response:
  - `en_o` rises 1 cycle after the last word.
  - Round 0: `Wt_o`=0x61626380, `Kt_o`=0x428a2f98.
  - Round 15: `Wt_o`=0x00000018.
  - Round 16: `Wt_o`=0x61626380.
  - Round 17: `Wt_o`=0x000f0000.
  - Round 63: `Kt_o`=0xc67178f2.
  - Exactly 64 `en_o` cycles, then a single `done_o` pulse.
- **Chained to `sha256_hash_core`:** pulse the core's `ld_i`, then run the "abc" block → core `A_o`=0x506e3058 after `done_o` (0xba7816bf once the IV 0x6a09e667 is added).
- **Throttled load:** deassert `word_valid_i` randomly during the 16 words → the same Wt sequence as the full-rate case. Words presented during RUN/DONE are not accepted (`word_ready_o`=0).
- **Reset mid-RUN:** assert `rst_n`=0 at round 30 → `en_o`=0 immediately. After release, a fresh "abc" block yields a correct round-0 `Wt_o`=0x61626380.
- **`SHA256_SCHED_STALL_EN`:** hold `stall_i` high for 5 cycles at `t`=20 → `en_o`=0 for those 5 cycles. Round 20 then resumes with an unchanged `Wt_o`, and `done_o` arrives 5 cycles later than in the unstalled case.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched
//   Message-schedule and round-constant stage feeding sha256_hash_core.
//   It loads one 512-bit block as 16 big-endian 32-bit words over valid/ready.
//   It then issues W_t / K_t for rounds 0..63, one round per cycle, using a
//   16-word sliding window (w_q[0] is the oldest word, i.e. W_t).
//
//   Optional feature macro: SHA256_SCHED_STALL_EN
//     When defined, adds stall_i. Stall is registered and gated to RUN, so a
//     stall seen on one edge suppresses issue during the following cycle. This
//     keeps en_o/Wt_o/Kt_o free of any input-to-output combinational path.
//
//   Ports
//     clk           in   clock, rising edge
//     rst_n         in   asynchronous active-low reset
//     word_valid_i  in   message word present on word_i
//     word_i        in   message word, W_0 first
//     word_ready_o  out  block can accept a word (IDLE/LOAD)
//     stall_i       in   (SHA256_SCHED_STALL_EN only) freeze round issue
//     en_o          out  round strobe to hash core en_i
//     Wt_o          out  schedule word for current round (0 when en_o=0)
//     Kt_o          out  round constant for current round (0 when en_o=0)
//     done_o        out  one-cycle pulse after round 63
// -----------------------------------------------------------------------------
module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        word_valid_i,
    input  logic [31:0] word_i,
    output logic        word_ready_o,
`ifdef SHA256_SCHED_STALL_EN
    input  logic        stall_i,
`endif
    output logic        en_o,
    output logic [31:0] Wt_o,
    output logic [31:0] Kt_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wc_q, wc_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];

    logic        load_phase_s;
    logic        accept_s;
    logic        advance_s;
    logic        shift_s;
    logic [31:0] shift_word_s;
    logic [31:0] new_w_s;

    // sigma0 = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1 = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    // FIPS 180-4 round constants K[0..63]
    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h00000000;
        endcase
        return k;
    endfunction

    assign load_phase_s = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept_s     = word_valid_i && load_phase_s;

    // The window holds W_t..W_{t+15}, so one uniform recurrence covers all rounds
    assign new_w_s = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

`ifdef SHA256_SCHED_STALL_EN
    logic stall_q, stall_d;

    // Registered stall, only captured while running
    always_comb begin
        if (state_q == S_RUN) begin
            stall_d = stall_i;
        end else begin
            stall_d = 1'b0;
        end
    end

    // Stall register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign advance_s = (state_q == S_RUN) && !stall_q;
`else
    assign advance_s = (state_q == S_RUN);
`endif

    // Next-state, counters and window update
    always_comb begin
        state_d      = state_q;
        wc_d         = wc_q;
        t_d          = t_q;
        shift_s      = 1'b0;
        shift_word_s = 32'h00000000;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    shift_s      = 1'b1;
                    shift_word_s = word_i;
                    wc_d         = 4'd1;
                    state_d      = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    shift_s      = 1'b1;
                    shift_word_s = word_i;
                    if (wc_q == 4'd15) begin
                        wc_d    = 4'd0;
                        t_d     = 6'd0;
                        state_d = S_RUN;
                    end else begin
                        wc_d = wc_q + 4'd1;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (advance_s) begin
                    shift_s      = 1'b1;
                    shift_word_s = new_w_s;
                    t_d          = t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < 15; i++) begin
            if (shift_s) begin
                w_d[i] = w_q[i + 1];
            end else begin
                w_d[i] = w_q[i];
            end
        end
        if (shift_s) begin
            w_d[15] = shift_word_s;
        end else begin
            w_d[15] = w_q[15];
        end
    end

    // State, counter and window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wc_q    <= 4'd0;
            t_q     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'h00000000;
            end
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            t_q     <= t_d;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        word_ready_o = load_phase_s;
        en_o         = advance_s;
        done_o       = (state_q == S_DONE);
        if (advance_s) begin
            Wt_o = w_q[0];
            Kt_o = k_rom(t_q);
        end else begin
            Wt_o = 32'h00000000;
            Kt_o = 32'h00000000;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against an array-based reference
// schedule (W[t] recurrence over a 64-entry array) and a local K table.
module tb_sha256_msg_sched;

    logic        clk;
    logic        rst_n;
    logic        word_valid_i;
    logic [31:0] word_i;
    logic        word_ready_o;
    logic        en_o;
    logic [31:0] Wt_o;
    logic [31:0] Kt_o;
    logic        done_o;
`ifdef SHA256_SCHED_STALL_EN
    logic        stall_i;
`endif

    sha256_msg_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_valid_i (word_valid_i),
        .word_i       (word_i),
        .word_ready_o (word_ready_o),
`ifdef SHA256_SCHED_STALL_EN
        .stall_i      (stall_i),
`endif
        .en_o         (en_o),
        .Wt_o         (Wt_o),
        .Kt_o         (Kt_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] blk [16];
    logic [31:0] mw  [64];
    logic        en_at_last;

    logic        cap_en   [100];
    logic [31:0] cap_wt   [100];
    logic [31:0] cap_kt   [100];
    logic        cap_done [100];
    logic        cap_rdy  [100];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule: W[0..15] = block, W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
    task automatic compute_model();
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                mw[t] = blk[t];
            end else begin
                s0 = rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3);
                s1 = rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10);
                mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
            end
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h00000000;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    // Presents blk[0..15]; returns at the negedge right after the 16th word is taken
    task automatic load_block(input bit throttle);
        for (int i = 0; i < 16; i++) begin
            int gaps;
            gaps = 0;
            @(negedge clk);
            while (throttle && gaps < 6 && $urandom_range(0, 2) == 0) begin
                word_valid_i = 1'b0;
                word_i       = $urandom;
                gaps++;
                @(negedge clk);
            end
            if (i == 15) en_at_last = en_o;
            word_valid_i = 1'b1;
            word_i       = blk[i];
        end
        @(negedge clk);
        word_valid_i = 1'b0;
        word_i       = 32'h00000000;
    endtask

    // Records outputs for ncyc cycles; with junk, offers words during RUN/DONE
    task automatic capture(input int ncyc, input bit junk);
        for (int c = 0; c < ncyc; c++) begin
            cap_en[c]   = en_o;
            cap_wt[c]   = Wt_o;
            cap_kt[c]   = Kt_o;
            cap_done[c] = done_o;
            cap_rdy[c]  = word_ready_o;
            if (junk && c <= 64) begin
                word_valid_i = 1'b1;
                word_i       = $urandom;
            end else begin
                word_valid_i = 1'b0;
                word_i       = 32'h00000000;
            end
            @(negedge clk);
        end
        word_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        word_valid_i = 1'b0;
        word_i       = 32'h00000000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (word_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", word_ready_o); end
        n_cmp++; if (en_o !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", en_o); end
        n_cmp++; if (Wt_o !== 32'h0) begin n_err++; $display("FAIL reset_wt: got %h want 00000000", Wt_o); end
        n_cmp++; if (Kt_o !== 32'h0) begin n_err++; $display("FAIL reset_kt: got %h want 00000000", Kt_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
    endtask

    task automatic test_abc();
        int en_cnt, done_cnt, bad_zero, bad_rdy;
        set_abc();
        compute_model();
        load_block(1'b0);
        capture(70, 1'b0);
        n_cmp++; if (en_at_last !== 1'b0) begin n_err++; $display("FAIL abc_en_before: got %b want 0", en_at_last); end
        n_cmp++; if (cap_en[0] !== 1'b1) begin n_err++; $display("FAIL abc_en_rise: got %b want 1", cap_en[0]); end
        n_cmp++; if (cap_wt[0] !== 32'h61626380) begin n_err++; $display("FAIL abc_w0: got %h want 61626380", cap_wt[0]); end
        n_cmp++; if (cap_kt[0] !== 32'h428a2f98) begin n_err++; $display("FAIL abc_k0: got %h want 428a2f98", cap_kt[0]); end
        n_cmp++; if (cap_wt[15] !== 32'h00000018) begin n_err++; $display("FAIL abc_w15: got %h want 00000018", cap_wt[15]); end
        n_cmp++; if (cap_wt[16] !== 32'h61626380) begin n_err++; $display("FAIL abc_w16: got %h want 61626380", cap_wt[16]); end
        n_cmp++; if (cap_wt[17] !== 32'h000f0000) begin n_err++; $display("FAIL abc_w17: got %h want 000f0000", cap_wt[17]); end
        n_cmp++; if (cap_kt[63] !== 32'hc67178f2) begin n_err++; $display("FAIL abc_k63: got %h want c67178f2", cap_kt[63]); end
        for (int t = 0; t < 64; t++) begin
            n_cmp++; if (cap_wt[t] !== mw[t]) begin n_err++; $display("FAIL abc_wt[%0d]: got %h want %h", t, cap_wt[t], mw[t]); end
            n_cmp++; if (cap_kt[t] !== K_TAB[t]) begin n_err++; $display("FAIL abc_kt[%0d]: got %h want %h", t, cap_kt[t], K_TAB[t]); end
        end
        en_cnt = 0; done_cnt = 0; bad_zero = 0; bad_rdy = 0;
        for (int c = 0; c < 70; c++) begin
            if (cap_en[c] === 1'b1) en_cnt++;
            if (cap_done[c] === 1'b1) done_cnt++;
            if (cap_en[c] !== 1'b1 && (cap_wt[c] !== 32'h0 || cap_kt[c] !== 32'h0)) bad_zero++;
            if (cap_rdy[c] !== (c >= 65 ? 1'b1 : 1'b0)) bad_rdy++;
        end
        n_cmp++; if (en_cnt !== 64) begin n_err++; $display("FAIL abc_en_count: got %0d want 64", en_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL abc_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (cap_done[64] !== 1'b1) begin n_err++; $display("FAIL abc_done_cycle: got %b want 1", cap_done[64]); end
        n_cmp++; if (bad_zero !== 0) begin n_err++; $display("FAIL abc_idle_zero: got %0d bad cycles want 0", bad_zero); end
        n_cmp++; if (bad_rdy !== 0) begin n_err++; $display("FAIL abc_ready: got %0d bad cycles want 0", bad_rdy); end
    endtask

    task automatic test_back_to_back();
        int bad;
        for (int b = 0; b < 3; b++) begin
            set_random();
            compute_model();
            load_block(1'b0);
            capture(66, 1'b0);
            bad = 0;
            for (int t = 0; t < 64; t++) begin
                if (cap_en[t] !== 1'b1 || cap_wt[t] !== mw[t] || cap_kt[t] !== K_TAB[t]) bad++;
            end
            n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL b2b_block%0d: got %0d bad rounds want 0 (w0 got %h want %h)", b, bad, cap_wt[0], mw[0]); end
            n_cmp++; if (cap_done[64] !== 1'b1 || cap_en[64] !== 1'b0) begin n_err++; $display("FAIL b2b_done%0d: got done=%b en=%b want done=1 en=0", b, cap_done[64], cap_en[64]); end
        end
    endtask

    task automatic test_throttled();
        int bad, bad_rdy;
        for (int b = 0; b < 2; b++) begin
            if (b == 0) set_abc(); else set_random();
            compute_model();
            load_block(1'b1);
            capture(68, 1'b1);
            bad = 0; bad_rdy = 0;
            for (int t = 0; t < 64; t++) begin
                if (cap_en[t] !== 1'b1 || cap_wt[t] !== mw[t]) bad++;
            end
            for (int c = 0; c <= 64; c++) begin
                if (cap_rdy[c] !== 1'b0) bad_rdy++;
            end
            n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL throttle_wt%0d: got %0d bad rounds want 0 (w0 got %h want %h)", b, bad, cap_wt[0], mw[0]); end
            n_cmp++; if (bad_rdy !== 0) begin n_err++; $display("FAIL throttle_ready%0d: got %0d ready cycles in RUN/DONE want 0", b, bad_rdy); end
            n_cmp++; if (cap_done[64] !== 1'b1) begin n_err++; $display("FAIL throttle_done%0d: got %b want 1", b, cap_done[64]); end
        end
    endtask

    task automatic test_reset_mid_load();
        int bad;
        set_random();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            word_valid_i = 1'b1;
            word_i       = blk[i];
        end
        @(negedge clk);
        word_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (word_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_load_ready: got %b want 1", word_ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
        set_abc();
        compute_model();
        load_block(1'b0);
        capture(66, 1'b0);
        bad = 0;
        for (int t = 0; t < 64; t++) if (cap_wt[t] !== mw[t] || cap_en[t] !== 1'b1) bad++;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rst_load_fresh: got %0d bad rounds want 0 (w0 got %h)", bad, cap_wt[0]); end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        set_abc();
        compute_model();
        load_block(1'b0);
        repeat (30) @(negedge clk);
        n_cmp++; if (en_o !== 1'b1 || Wt_o !== mw[30]) begin n_err++; $display("FAIL rst_run_r30: got en=%b wt=%h want en=1 wt=%h", en_o, Wt_o, mw[30]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (en_o !== 1'b0) begin n_err++; $display("FAIL rst_run_en: got %b want 0", en_o); end
        n_cmp++; if (Wt_o !== 32'h0 || Kt_o !== 32'h0) begin n_err++; $display("FAIL rst_run_wk: got %h/%h want 0/0", Wt_o, Kt_o); end
        n_cmp++; if (word_ready_o !== 1'b1 || done_o !== 1'b0) begin n_err++; $display("FAIL rst_run_rdy_done: got %b/%b want 1/0", word_ready_o, done_o); end
        @(negedge clk);
        n_cmp++; if (en_o !== 1'b0) begin n_err++; $display("FAIL rst_run_en_held: got %b want 0", en_o); end
        rst_n = 1'b1;
        load_block(1'b0);
        capture(66, 1'b0);
        n_cmp++; if (cap_wt[0] !== 32'h61626380) begin n_err++; $display("FAIL rst_run_w0: got %h want 61626380", cap_wt[0]); end
        bad = 0;
        for (int t = 0; t < 64; t++) if (cap_wt[t] !== mw[t]) bad++;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rst_run_seq: got %0d bad rounds want 0", bad); end
    endtask

`ifdef SHA256_SCHED_STALL_EN
    task automatic test_stall();
        int issued, done_c, low_in_run, left, bad;
        bit fired;
        logic [31:0] got [64];
        issued = 0; done_c = -1; low_in_run = 0; left = 0; fired = 1'b0;
        set_random();
        compute_model();
        load_block(1'b0);
        for (int c = 0; c < 100; c++) begin
            if (done_o === 1'b1 && done_c < 0) done_c = c;
            if (en_o === 1'b1) begin
                if (issued < 64) got[issued] = Wt_o;
                issued++;
            end else if (done_c < 0) begin
                low_in_run++;
            end
            if (left > 0) begin
                left--;
                if (left == 0) stall_i = 1'b0;
            end
            if (!fired && en_o === 1'b1 && issued == 20) begin
                fired   = 1'b1;
                stall_i = 1'b1;
                left    = 5;
            end
            @(negedge clk);
        end
        stall_i = 1'b0;
        bad = 0;
        for (int t = 0; t < 64 && t < issued; t++) if (got[t] !== mw[t]) bad++;
        n_cmp++; if (issued !== 64) begin n_err++; $display("FAIL stall_rounds: got %0d want 64", issued); end
        n_cmp++; if (low_in_run !== 5) begin n_err++; $display("FAIL stall_gap: got %0d want 5", low_in_run); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_seq: got %0d bad rounds want 0", bad); end
        n_cmp++; if (done_c !== 69) begin n_err++; $display("FAIL stall_done: got cycle %0d want 69", done_c); end
    endtask
`endif

    initial begin
`ifdef SHA256_SCHED_STALL_EN
        stall_i = 1'b0;
`endif
        test_reset();
        test_abc();
        test_back_to_back();
        test_throttled();
        test_reset_mid_load();
        test_reset_mid_run();
`ifdef SHA256_SCHED_STALL_EN
        test_stall();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
